// File: rtl/rr_trace_split.sv
// Replay-side trace unpacker: splits the dense ALIGN-aligned DRAM bitstream back
// into variable-width records, each emitted LSB-aligned together with its width.
module rr_trace_split #(
  parameter int WIDTH        = 2560,
  parameter int AXI_WIDTH    = 512,
  parameter int ALIGN        = 32,
  parameter int OFFSET_WIDTH = 32,
  parameter int LEN_BITS     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AXI_WIDTH-1:0]    replay_in_fifo_out,
  input  logic                    replay_in_fifo_empty,
  output logic                    replay_in_fifo_rd_en,
  output logic [WIDTH-1:0]        replay_out_fifo_in,
  output logic [OFFSET_WIDTH-1:0] replay_out_fifo_in_width,
  output logic                    replay_out_fifo_wr_en,
  input  logic                    replay_out_fifo_almfull,
  output logic [31:0]             replay_record_cnt,
  output logic                    replay_err
);

  localparam int BUF_W  = WIDTH + AXI_WIDTH;
  localparam int FILL_W = $clog2(BUF_W) + 1;

  localparam logic [31:0]       ALIGN_U  = 32'(ALIGN);
  localparam logic [31:0]       WIDTH_U  = 32'(WIDTH);
  localparam logic [FILL_W-1:0] ALIGN_F  = FILL_W'(ALIGN);
  localparam logic [FILL_W-1:0] WIDTH_F  = FILL_W'(WIDTH);
  localparam logic [FILL_W-1:0] AXI_F    = FILL_W'(AXI_WIDTH);
  localparam logic [FILL_W-1:0] AXI_MASK = FILL_W'(AXI_WIDTH - 1);
  localparam logic [FILL_W-1:0] ONE_F    = FILL_W'(1);

  logic [BUF_W-1:0]        r_buf;
  logic [FILL_W-1:0]       r_fill;
  logic                    r_err;
  logic [WIDTH-1:0]        r_data;
  logic [OFFSET_WIDTH-1:0] r_width;
  logic                    r_wr_en;
  logic [31:0]             r_cnt;

  logic [LEN_BITS-1:0]     w_hdr;
  logic                    w_hdr_valid;
  logic                    w_hdr_zero;
  logic                    w_hdr_legal;
  logic                    w_hdr_fits;
  logic                    w_pop;
  logic                    w_emit;
  logic                    w_pad;
  logic                    w_bad;
  logic [FILL_W-1:0]       w_consumed;
  logic [FILL_W-1:0]       w_ins_at;
  logic [FILL_W-1:0]       w_fill_next;
  logic [BUF_W-1:0]        w_buf_next;
  logic [WIDTH-1:0]        w_mask;

  assign w_hdr       = r_buf[LEN_BITS-1:0];
  assign w_hdr_valid = (r_fill >= ALIGN_F);
  assign w_hdr_zero  = (w_hdr == '0);
  assign w_hdr_legal = ((32'(w_hdr) % ALIGN_U) == 32'd0) && (32'(w_hdr) <= WIDTH_U);
  assign w_hdr_fits  = (32'(w_hdr) <= 32'(r_fill));

  // Popping whenever fill <= WIDTH guarantees any legal record eventually fits.
  assign w_pop  = ~replay_in_fifo_empty & (r_fill <= WIDTH_F) & ~r_err;
  assign w_emit = w_hdr_valid & ~w_hdr_zero & w_hdr_legal & w_hdr_fits
                & ~replay_out_fifo_almfull & ~r_err;
  assign w_pad  = w_hdr_valid & w_hdr_zero & ~r_err;
  assign w_bad  = w_hdr_valid & ~w_hdr_zero & ~w_hdr_legal & ~r_err;

  assign replay_in_fifo_rd_en = w_pop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_consumed = '0;
    if (w_emit) begin
      w_consumed = FILL_W'(w_hdr);
    end else if (w_pad) begin
      // Fill always ends on a word boundary, so this is the rest of the pad's own word.
      w_consumed = ((r_fill - ONE_F) & AXI_MASK) + ONE_F;
    end
  end

  assign w_ins_at    = r_fill - w_consumed;
  assign w_fill_next = r_fill - w_consumed + (w_pop ? AXI_F : '0);
  assign w_mask      = ~({WIDTH{1'b1}} << w_hdr);

  always_comb begin
    w_buf_next = r_buf >> w_consumed;
    if (w_pop) begin
      // Bits at and above fill are always zero, so the new word can be OR-ed in.
      w_buf_next = w_buf_next | (BUF_W'(replay_in_fifo_out) << w_ins_at);
    end
  end

  // NOTE: the buffer is cleared on reset because word insertion relies on the
  // bits above fill being zero; it is a shift register, not a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf   <= '0;
      r_fill  <= '0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_width <= '0;
      r_wr_en <= 1'b0;
      r_cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values computed above.
      r_buf   <= w_buf_next;
      r_fill  <= w_fill_next;
      r_wr_en <= w_emit;
      if (w_bad) begin
        r_err <= 1'b1;
      end
      if (w_emit) begin
        r_data  <= r_buf[WIDTH-1:0] & w_mask;
        r_width <= OFFSET_WIDTH'(w_hdr);
        r_cnt   <= r_cnt + 32'd1;
      end
    end
  end

  assign replay_out_fifo_in       = r_data;
  assign replay_out_fifo_in_width = r_width;
  assign replay_out_fifo_wr_en    = r_wr_en;
  assign replay_record_cnt        = r_cnt;
  assign replay_err               = r_err;

endmodule

// File: tb/tb_rr_trace_split.sv
// Self-checking bench for rr_trace_split: a bench-side packer builds the DRAM word
// stream from a record list, and pushes are scored against that list in order.
module tb_rr_trace_split;

  localparam int WIDTH        = 2560;
  localparam int AXI_W        = 512;
  localparam int ALIGN        = 32;
  localparam int OFFSET_WIDTH = 32;
  localparam int LEN_BITS     = 16;

  typedef struct {
    int               w;
    logic [WIDTH-1:0] d;
  } rec_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [AXI_W-1:0]        replay_in_fifo_out;
  logic                    replay_in_fifo_empty;
  logic                    replay_in_fifo_rd_en;
  logic [WIDTH-1:0]        replay_out_fifo_in;
  logic [OFFSET_WIDTH-1:0] replay_out_fifo_in_width;
  logic                    replay_out_fifo_wr_en;
  logic                    replay_out_fifo_almfull;
  logic [31:0]             replay_record_cnt;
  logic                    replay_err;

  always #5 clk = ~clk;

  rr_trace_split #(
    .WIDTH(WIDTH), .AXI_WIDTH(AXI_W), .ALIGN(ALIGN),
    .OFFSET_WIDTH(OFFSET_WIDTH), .LEN_BITS(LEN_BITS)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .replay_in_fifo_out       (replay_in_fifo_out),
    .replay_in_fifo_empty     (replay_in_fifo_empty),
    .replay_in_fifo_rd_en     (replay_in_fifo_rd_en),
    .replay_out_fifo_in       (replay_out_fifo_in),
    .replay_out_fifo_in_width (replay_out_fifo_in_width),
    .replay_out_fifo_wr_en    (replay_out_fifo_wr_en),
    .replay_out_fifo_almfull  (replay_out_fifo_almfull),
    .replay_record_cnt        (replay_record_cnt),
    .replay_err               (replay_err)
  );

  int checks = 0;
  int failures = 0;

  logic [AXI_W-1:0] word_q[$];
  logic [AXI_W-1:0] stage_q[$];
  rec_t             exp_q[$];
  logic [AXI_W-1:0] pk_word;
  int               pk_pos;

  int               step_no = 0;
  int               words_popped = 0;
  int               first_pop_step = -1;
  int               push_step = 0;
  int               n_push = 0;
  int               exp_cnt = 0;
  int               bubble_pct = 0;
  logic             prev_af = 1'b0;
  int               last_w = 0;
  logic [WIDTH-1:0] last_data = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [WIDTH-1:0] obs,
                            input logic [WIDTH-1:0] exp);
    int idx;
    idx = 0;
    for (int i = WIDTH - 1; i >= 0; i--) if (obs[i] !== exp[i]) idx = i;
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: first differing bit %0d observed=%0b expected=%0b",
             tag, idx, obs[idx], exp[idx]);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_vec();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AXI_W-1:0] rand_word();
    logic [AXI_W-1:0] v;
    for (int i = 0; i < AXI_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive_fifo();
    if (word_q.size() == 0 || $urandom_range(99) < bubble_pct) begin
      replay_in_fifo_empty = 1'b1;
      replay_in_fifo_out   = '0;
    end else begin
      replay_in_fifo_empty = 1'b0;
      replay_in_fifo_out   = word_q[0];
    end
  endtask

  // One clock: observe at the falling edge, then update the FIFO model after the rise.
  task automatic step();
    logic popped;
    rec_t e;
    @(negedge clk);
    step_no++;
    popped = replay_in_fifo_rd_en;
    if (replay_out_fifo_wr_en) begin
      n_push++;
      push_step = step_no;
      last_w    = int'(replay_out_fifo_in_width);
      last_data = replay_out_fifo_in;
      check("almfull_gate", 64'(prev_af), 64'd0);
      check("push_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rec_width", 64'(replay_out_fifo_in_width), 64'(e.w));
        check_data("rec_data", replay_out_fifo_in, e.d);
      end
    end
    prev_af = replay_out_fifo_almfull;
    @(posedge clk);
    #1;
    if (popped && word_q.size() > 0) begin
      void'(word_q.pop_front());
      words_popped++;
      if (first_pop_step < 0) first_pop_step = step_no;
    end
    drive_fifo();
  endtask

  task automatic pack_chunk(input logic [31:0] c);
    pk_word[pk_pos +: 32] = c;
    pk_pos += 32;
    if (pk_pos == AXI_W) begin
      stage_q.push_back(pk_word);
      pk_word = rand_word();
      pk_pos  = 0;
    end
  endtask

  task automatic add_record(input int w, input logic [WIDTH-1:0] payload);
    logic [WIDTH-1:0] m;
    rec_t r;
    m = '1;
    m = m >> (WIDTH - w);
    r.w = w;
    r.d = payload & m;
    r.d[LEN_BITS-1:0] = LEN_BITS'(w);
    for (int i = 0; i < w / 32; i++) pack_chunk(r.d[i*32 +: 32]);
    exp_q.push_back(r);
    exp_cnt++;
  endtask

  task automatic add_pad();
    pk_word[pk_pos +: LEN_BITS] = '0;
    stage_q.push_back(pk_word);
    pk_word = rand_word();
    pk_pos  = 0;
  endtask

  task automatic flush_and_load();
    if (pk_pos != 0) add_pad();
    while (stage_q.size() > 0) word_q.push_back(stage_q.pop_front());
    drive_fifo();
  endtask

  task automatic drain(input string tag, input int limit);
    int n;
    n = 0;
    while ((word_q.size() > 0 || exp_q.size() > 0) && n < limit) begin
      step();
      n++;
    end
    repeat (4) step();
    check({tag, "_records_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_words_left"}, 64'(word_q.size()), 64'd0);
    check({tag, "_cnt"}, 64'(replay_record_cnt), 64'(exp_cnt));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    word_q.delete();
    exp_q.delete();
    exp_cnt = 0;
    drive_fifo();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AXI_W-1:0] w0;
    rec_t r;
    int   n0;
    int   snap;
    int   n;

    replay_out_fifo_almfull = 1'b0;
    pk_word = rand_word();
    pk_pos  = 0;
    drive_fifo();

    // Reset state, observed before any clock edge.
    #2;
    check("rst_wr_en", 64'(replay_out_fifo_wr_en), 64'd0);
    check("rst_cnt", 64'(replay_record_cnt), 64'd0);
    check("rst_err", 64'(replay_err), 64'd0);
    check("rst_width", 64'(replay_out_fifo_in_width), 64'd0);
    check("rst_data_zero", 64'(|replay_out_fifo_in), 64'd0);
    check("rst_rd_en", 64'(replay_in_fifo_rd_en), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;

    // Single 64-bit record with a known payload; rest of the word is padding.
    w0 = rand_word();
    w0[31:0]  = {16'h0000, 16'd64};
    w0[63:32] = 32'hDEAD_BEEF;
    w0[64 +: LEN_BITS] = '0;
    r.w = 64;
    r.d = '0;
    r.d[63:0] = w0[63:0];
    exp_q.push_back(r);
    exp_cnt++;
    word_q.push_back(w0);
    drive_fifo();
    first_pop_step = -1;
    n_push = 0;
    repeat (6) step();
    check("t1_pushes", 64'(n_push), 64'd1);
    check("t1_latency", 64'(push_step - first_pop_step), 64'd2);
    check("t1_width", 64'(last_w), 64'd64);
    check("t1_payload", 64'(last_data[63:32]), 64'hDEAD_BEEF);
    check("t1_upper_zero", 64'(|last_data[WIDTH-1:64]), 64'd0);
    check("t1_cnt", 64'(replay_record_cnt), 64'd1);
    check("t1_rd_en_idle", 64'(replay_in_fifo_rd_en), 64'd0);

    // 480 + 96 across a word boundary, tail of word 1 padded.
    n0 = n_push;
    add_record(480, rand_vec());
    add_record(96, rand_vec());
    flush_and_load();
    drain("t2", 100);
    check("t2_pushes", 64'(n_push - n0), 64'd2);

    // Full-width record across 5 words; pops must stop once fill exceeds WIDTH.
    add_record(2560, rand_vec());
    add_record(32, rand_vec());
    add_pad();
    add_record(64, rand_vec());
    replay_out_fifo_almfull = 1'b1;
    flush_and_load();
    words_popped = 0;
    repeat (12) step();
    check("t3_pops_stalled", 64'(words_popped), 64'd6);
    check("t3_rd_en_stall", 64'(replay_in_fifo_rd_en), 64'd0);
    check("t3_fifo_pending", 64'(word_q.size()), 64'd1);
    replay_out_fifo_almfull = 1'b0;
    drain("t3", 100);

    // Eight back-to-back 128-bit records with almfull held for 10 cycles.
    n0 = n_push;
    for (int i = 0; i < 8; i++) add_record(128, rand_vec());
    flush_and_load();
    repeat (3) step();
    replay_out_fifo_almfull = 1'b1;
    repeat (10) step();
    replay_out_fifo_almfull = 1'b0;
    drain("t4", 100);
    check("t4_pushes", 64'(n_push - n0), 64'd8);

    // Random stream with pads, FIFO bubbles and almfull toggling.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(99) < 15) add_pad();
      if ($urandom_range(1) == 0) add_record(32 * $urandom_range(1, 8), rand_vec());
      else add_record(32 * $urandom_range(1, WIDTH / 32), rand_vec());
    end
    bubble_pct = 20;
    flush_and_load();
    n = 0;
    while ((word_q.size() > 0 || exp_q.size() > 0) && n < 20000) begin
      replay_out_fifo_almfull = ($urandom_range(99) < 30);
      step();
      n++;
    end
    replay_out_fifo_almfull = 1'b0;
    bubble_pct = 0;
    drain("rand", 100);

    // Unaligned header 100 after one good record.
    do_reset();
    w0 = rand_word();
    w0[LEN_BITS-1:0] = LEN_BITS'(64);
    w0[64 +: LEN_BITS] = LEN_BITS'(100);
    r.w = 64;
    r.d = '0;
    r.d[63:0] = w0[63:0];
    exp_q.push_back(r);
    exp_cnt++;
    word_q.push_back(w0);
    for (int i = 0; i < 5; i++) word_q.push_back(rand_word());
    drive_fifo();
    repeat (8) step();
    check("t5a_err", 64'(replay_err), 64'd1);
    snap = words_popped;
    repeat (10) step();
    check("t5a_no_pops", 64'(words_popped - snap), 64'd0);
    check("t5a_rd_en", 64'(replay_in_fifo_rd_en), 64'd0);
    check("t5a_err_sticky", 64'(replay_err), 64'd1);
    check("t5a_cnt", 64'(replay_record_cnt), 64'd1);
    check("t5a_records_left", 64'(exp_q.size()), 64'd0);

    // Oversized header 2592; flag clears only through reset.
    do_reset();
    check("t5b_err_cleared", 64'(replay_err), 64'd0);
    w0 = rand_word();
    w0[LEN_BITS-1:0] = LEN_BITS'(2592);
    word_q.push_back(w0);
    for (int i = 0; i < 5; i++) word_q.push_back(rand_word());
    drive_fifo();
    repeat (6) step();
    check("t5b_err", 64'(replay_err), 64'd1);
    snap = words_popped;
    repeat (10) step();
    check("t5b_no_pops", 64'(words_popped - snap), 64'd0);
    check("t5b_err_sticky", 64'(replay_err), 64'd1);
    check("t5b_cnt", 64'(replay_record_cnt), 64'd0);
    #2;
    rst_n = 1'b0;
    word_q.delete();
    drive_fifo();
    #1;
    check("t5b_err_async_clear", 64'(replay_err), 64'd0);
    step();
    rst_n = 1'b1;
    exp_cnt = 0;

    // Asynchronous reset while a 1024-bit record is half buffered.
    add_record(64, rand_vec());
    add_record(1024, rand_vec());
    if (pk_pos != 0) add_pad();
    word_q.push_back(stage_q.pop_front());
    stage_q.delete();
    drive_fifo();
    repeat (5) step();
    check("t6_cnt_before", 64'(replay_record_cnt), 64'd1);
    #2;
    rst_n = 1'b0;
    word_q.delete();
    exp_q.delete();
    exp_cnt = 0;
    drive_fifo();
    #1;
    check("t6_wr_en", 64'(replay_out_fifo_wr_en), 64'd0);
    check("t6_cnt", 64'(replay_record_cnt), 64'd0);
    check("t6_width", 64'(replay_out_fifo_in_width), 64'd0);
    check("t6_data_zero", 64'(|replay_out_fifo_in), 64'd0);
    check("t6_err", 64'(replay_err), 64'd0);
    check("t6_rd_en", 64'(replay_in_fifo_rd_en), 64'd0);
    repeat (3) step();
    check("t6_held_cnt", 64'(replay_record_cnt), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) add_record(32 * $urandom_range(1, 40), rand_vec());
    flush_and_load();
    drain("t6", 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
